chess_clock_ctrl: RTL and testbench



---
 rtl/chess_clock_pkg.sv | 30 +++
 rtl/chess_clock_ctrl_if.sv | 33 +++
 rtl/chess_timer_chan.sv | 60 ++++++
 rtl/chess_clock_ctrl.sv | 131 +++++++++++++
 tb/tb_chess_clock_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/chess_clock_pkg.sv
// Shared definitions for the chess clock controller.
// Holds the game state encoding, the side-to-move encoding, the button
// indices used by the input conditioning loop, and the per-timer control
// record handed from the game FSM to each timer channel.
package chess_clock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_FLAG  = 2'd3
   } state_e;

   localparam logic PLAYER_WHITE = 1'b0;
   localparam logic PLAYER_BLACK = 1'b1;

   // Raw button vector layout: {button2, button1, start_button}
   localparam int NUM_BTN   = 3;
   localparam int BTN_START = 0;
   localparam int BTN_WHITE = 1;
   localparam int BTN_BLACK = 2;

   // Per-channel command from the FSM
   typedef struct packed {
      logic load;    // hold/reload START_TIME, clear flag
      logic dec;     // one time unit elapsed for this side
      logic inc_en;  // valid move by this side (increment build only)
   } chan_ctl_t;

endpackage

// File: rtl/chess_clock_ctrl_if.sv
// Board-side signal bundle of the chess clock controller.
// master: the board/bench (drives raw buttons, observes outputs)
// slave : the controller (samples raw buttons, drives status and times)
//   start_button, button1, button2 : raw asynchronous push-buttons
//   running, paused, player        : game status
//   time1, time2                   : remaining time, white / black
//   zero1, zero2                   : flag of white / black
//   tick                           : one-cycle pulse per elapsed time unit
interface chess_clock_ctrl_if #(
   parameter int TIME_W = 8
);
   logic              start_button;
   logic              button1;
   logic              button2;
   logic              running;
   logic              paused;
   logic              player;
   logic [TIME_W-1:0] time1;
   logic [TIME_W-1:0] time2;
   logic              zero1;
   logic              zero2;
   logic              tick;

   modport master (
      output start_button, button1, button2,
      input  running, paused, player, time1, time2, zero1, zero2, tick
   );

   modport slave (
      input  start_button, button1, button2,
      output running, paused, player, time1, time2, zero1, zero2, tick
   );
endinterface

// File: rtl/chess_timer_chan.sv
// One player's countdown timer.
// Decrements on dec (never below 0), optionally adds INC on a valid move
// with saturation at all-ones, and raises a sticky zero flag on the edge
// that takes the count from 1 to 0. load reloads START_TIME and clears
// the flag; load has priority over everything else.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   ctl_i         : {load, dec, inc_en}
//   time_o        : remaining time
//   zero_o        : flag, registered together with the 0 count
module chess_timer_chan
   import chess_clock_pkg::*;
#(
   parameter int TIME_W     = 8,
   parameter int START_TIME = 60,
   parameter int INC        = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  chan_ctl_t         ctl_i,
   output logic [TIME_W-1:0] time_o,
   output logic              zero_o
);

   localparam logic [TIME_W-1:0] T_MAX = '1;

   logic [TIME_W-1:0] time_q, time_d, dec_v;
   logic [TIME_W:0]   sum;
   logic              zero_q, zero_d;

   always_comb begin
      // decrement first, then increment the decremented value
      dec_v  = (ctl_i.dec && (time_q != '0)) ? time_q - TIME_W'(1) : time_q;
      sum    = {1'b0, dec_v} + (TIME_W+1)'(INC);
      time_d = dec_v;
      zero_d = zero_q;
      if (ctl_i.load) begin
         time_d = TIME_W'(START_TIME);
         zero_d = 1'b0;
      end else begin
         if (ctl_i.inc_en)
            time_d = sum[TIME_W] ? T_MAX : sum[TIME_W-1:0];
         if (ctl_i.dec && (time_q == TIME_W'(1)))
            zero_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         time_q <= TIME_W'(START_TIME);
         zero_q <= 1'b0;
      end else begin
         time_q <= time_d;
         zero_q <= zero_d;
      end
   end

   assign time_o = time_q;
   assign zero_o = zero_q;

endmodule

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock game controller.
// Conditions three raw buttons (2-flop sync + edge detect), runs a tick
// prescaler while in RUN, and steers ticks / moves into two timer
// channels. Game states: IDLE -> RUN <-> PAUSE, RUN -> FLAG -> IDLE.
// Optional build macro FISCHER_INC_EN: a valid move adds INC_TIME to the
// mover's timer (saturating); without it no increment is ever requested.
//   clk_one : system clock
//   reset_n : asynchronous active-low reset
//   ctl_if  : chess_clock_ctrl_if.slave (raw buttons in, status/times out)
module chess_clock_ctrl
   import chess_clock_pkg::*;
#(
   parameter int TIME_W     = 8,
   parameter int START_TIME = 60,
   parameter int TICK_DIV   = 4,
   parameter int INC_TIME   = 2
) (
   input  logic                clk_one,
   input  logic                reset_n,
   chess_clock_ctrl_if.slave   ctl_if
);

   localparam int PW = $clog2(TICK_DIV);

   // ---------------- button conditioning ----------------
   logic [NUM_BTN-1:0] btn_raw, press;

   assign btn_raw = {ctl_if.button2, ctl_if.button1, ctl_if.start_button};

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      // [0] sync1, [1] sync2, [2] previous value of sync2
      logic [2:0] sh_q;
      always_ff @(posedge clk_one or negedge reset_n) begin
         if (!reset_n) sh_q <= '0;
         else          sh_q <= {sh_q[1:0], btn_raw[g]};
      end
      assign press[g] = sh_q[1] & ~sh_q[2];
   end

   // ---------------- game FSM ----------------
   state_e                   state_q, state_d;
   logic                     player_q, player_d;
   logic [PW-1:0]            presc_q, presc_d;
   logic [1:0][TIME_W-1:0]   tm;
   logic [1:0]               zero;
   chan_ctl_t [1:0]          ctl;
   logic                     tick, start_p, mv_p, flag_hit, move_ok;

   assign tick    = (state_q == ST_RUN) && (presc_q == PW'(TICK_DIV-1));
   assign start_p = press[BTN_START];
   // only the side to move may end its turn
   assign mv_p    = (player_q == PLAYER_WHITE) ? press[BTN_WHITE] : press[BTN_BLACK];
   // this tick empties the mover's clock: flag beats pause and move
   assign flag_hit = tick && (tm[player_q] == TIME_W'(1));
   assign move_ok  = (state_q == ST_RUN) && mv_p && !start_p && !flag_hit;

   always_comb begin
      state_d  = state_q;
      player_d = player_q;
      presc_d  = presc_q;
      case (state_q)
         ST_IDLE: begin
            player_d = PLAYER_WHITE;
            presc_d  = '0;
            if (start_p) state_d = ST_RUN;
         end
         ST_RUN: begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (flag_hit)     state_d = ST_FLAG;
            else if (start_p) state_d = ST_PAUSE;
            else if (move_ok) begin
               player_d = ~player_q;
               presc_d  = '0;  // each turn starts with a full time unit
            end
         end
         ST_PAUSE: if (start_p) state_d = ST_RUN;  // prescaler resumes as frozen
         ST_FLAG:  if (start_p) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_one or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         player_q <= PLAYER_WHITE;
         presc_q  <= '0;
      end else begin
         state_q  <= state_d;
         player_q <= player_d;
         presc_q  <= presc_d;
      end
   end

   // ---------------- timer channels ----------------
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         // reload on the same edge that enters IDLE so times show START at once
         ctl[i].load   = (state_d == ST_IDLE);
         ctl[i].dec    = tick && (player_q == 1'(i));
`ifdef FISCHER_INC_EN
         ctl[i].inc_en = move_ok && (player_q == 1'(i));
`else
         ctl[i].inc_en = 1'b0;
`endif
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_chan
      chess_timer_chan #(
         .TIME_W    (TIME_W),
         .START_TIME(START_TIME),
         .INC       (INC_TIME)
      ) u_chan (
         .clk_i (clk_one),
         .rst_ni(reset_n),
         .ctl_i (ctl[g]),
         .time_o(tm[g]),
         .zero_o(zero[g])
      );
   end

   assign ctl_if.running = (state_q == ST_RUN);
   assign ctl_if.paused  = (state_q == ST_PAUSE);
   assign ctl_if.player  = player_q;
   assign ctl_if.time1   = tm[0];
   assign ctl_if.time2   = tm[1];
   assign ctl_if.zero1   = zero[0];
   assign ctl_if.zero2   = zero[1];
   assign ctl_if.tick    = tick;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Self-checking bench for chess_clock_ctrl (TIME_W=4, START_TIME=3,
// TICK_DIV=4, INC_TIME=2). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_chess_clock_ctrl;

   typedef struct packed {
      logic       run;
      logic       pau;
      logic       ply;
      logic [3:0] t1;
      logic [3:0] t2;
      logic       z1;
      logic       z2;
      logic       tk;
   } out_t;

   typedef struct {
      int   n;
      logic s;
      logic b1;
      logic b2;
      out_t exp;
   } vec_t;

   localparam out_t IDLE_O = '{run:1'b0, pau:1'b0, ply:1'b0, t1:4'd3, t2:4'd3,
                               z1:1'b0, z2:1'b0, tk:1'b0};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   vec_t vt[$];
   out_t sb[$];

   chess_clock_ctrl_if #(.TIME_W(4)) io();

   chess_clock_ctrl #(
      .TIME_W(4), .START_TIME(3), .TICK_DIV(4), .INC_TIME(2)
   ) dut (
      .clk_one(clk),
      .reset_n(rst_n),
      .ctl_if (io)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic out_t cur_out();
      out_t o;
      o = '{run:io.running, pau:io.paused, ply:io.player, t1:io.time1, t2:io.time2,
            z1:io.zero1, z2:io.zero2, tk:io.tick};
      return o;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input out_t act, input out_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got run=%b pau=%b ply=%b t1=%0d t2=%0d z=%b%b tk=%b want run=%b pau=%b ply=%b t1=%0d t2=%0d z=%b%b tk=%b",
                  nm, act.run, act.pau, act.ply, act.t1, act.t2, act.z1, act.z2, act.tk,
                  exp.run, exp.pau, exp.ply, exp.t1, exp.t2, exp.z1, exp.z2, exp.tk);
      end
   endtask

   task automatic addv(input int n, input logic s, input logic b1, input logic b2,
                       input logic r, input logic p, input logic pl,
                       input int t1, input int t2,
                       input logic z1, input logic z2, input logic tk);
      vec_t v;
      v.n  = n;
      v.s  = s;
      v.b1 = b1;
      v.b2 = b2;
      v.exp = '{run:r, pau:p, ply:pl, t1:4'(t1), t2:4'(t2), z1:z1, z2:z2, tk:tk};
      vt.push_back(v);
   endtask

   // Holds reset for two cycles, checks reset values, releases on a falling edge.
   task automatic do_reset(input string nm);
      rst_n = 1'b0;
      io.start_button = 1'b0;
      io.button1 = 1'b0;
      io.button2 = 1'b0;
      repeat (2) @(negedge clk);
      chk_out({nm, "_rst"}, cur_out(), IDLE_O);
      rst_n = 1'b1;
   endtask

   initial begin
      io.start_button = 1'b0;
      io.button1 = 1'b0;
      io.button2 = 1'b0;

      // One game: start, moves, ignored idle button, pause+move collision,
      // resume, flag, ignored moves in FLAG, restart to IDLE.
      //   n  s b1 b2  run pau ply t1 t2 z1 z2 tk
      addv(1, 1,0,0,  0,0,0, 3,3, 0,0,0);
      addv(1, 0,0,0,  0,0,0, 3,3, 0,0,0);
      addv(3, 0,0,0,  1,0,0, 3,3, 0,0,0);
      addv(1, 0,0,0,  1,0,0, 3,3, 0,0,1);
      addv(1, 0,1,0,  1,0,0, 2,3, 0,0,0);
      addv(1, 0,1,0,  1,0,0, 2,3, 0,0,0);
      addv(2, 0,1,0,  1,0,1, 2,3, 0,0,0);
      addv(1, 0,0,0,  1,0,1, 2,3, 0,0,0);
      addv(1, 0,0,0,  1,0,1, 2,3, 0,0,1);
      addv(1, 0,1,0,  1,0,1, 2,2, 0,0,0);
      addv(2, 0,0,0,  1,0,1, 2,2, 0,0,0);
      addv(1, 0,0,0,  1,0,1, 2,2, 0,0,1);
      addv(1, 0,0,1,  1,0,1, 2,1, 0,0,0);
      addv(1, 0,0,0,  1,0,1, 2,1, 0,0,0);
      addv(3, 0,0,0,  1,0,0, 2,1, 0,0,0);
      addv(1, 0,0,0,  1,0,0, 2,1, 0,0,1);
      addv(1, 1,1,0,  1,0,0, 1,1, 0,0,0);
      addv(1, 0,0,0,  1,0,0, 1,1, 0,0,0);
      addv(10,0,0,0,  0,1,0, 1,1, 0,0,0);
      addv(1, 1,0,0,  0,1,0, 1,1, 0,0,0);
      addv(1, 0,0,0,  0,1,0, 1,1, 0,0,0);
      addv(1, 0,0,0,  1,0,0, 1,1, 0,0,0);
      addv(1, 0,0,0,  1,0,0, 1,1, 0,0,1);
      addv(1, 0,0,0,  0,0,0, 0,1, 1,0,0);
      addv(4, 0,1,0,  0,0,0, 0,1, 1,0,0);
      addv(1, 0,0,0,  0,0,0, 0,1, 1,0,0);
      addv(1, 1,0,0,  0,0,0, 0,1, 1,0,0);
      addv(1, 0,0,0,  0,0,0, 0,1, 1,0,0);
      addv(1, 0,0,0,  0,0,0, 3,3, 0,0,0);

      // ---- reset, then idle 20 cycles ----
      do_reset("idle");
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk_out($sformatf("idle%0d", c), cur_out(), IDLE_O);
      end

`ifndef FISCHER_INC_EN
      // ---- table-driven game, scoreboard checked one cycle after drive ----
      foreach (vt[i]) begin
         for (int c = 0; c < vt[i].n; c++) begin
            io.start_button = vt[i].s;
            io.button1 = vt[i].b1;
            io.button2 = vt[i].b2;
            sb.push_back(vt[i].exp);
            @(negedge clk);
            chk_out($sformatf("vec%0d.%0d", i, c), cur_out(), sb.pop_front());
         end
      end
      io.start_button = 1'b0;
      io.button1 = 1'b0;
      io.button2 = 1'b0;
`endif

      // ---- tick and move coincide at time1=1: flag wins ----
      do_reset("coin");
      io.start_button = 1'b1;
      @(negedge clk);
      io.start_button = 1'b0;
      repeat (11) @(negedge clk);
      io.button1 = 1'b1;
      @(negedge clk);
      io.button1 = 1'b0;
      @(negedge clk);
      chk("coin_tick", int'(io.tick), 1);
      chk("coin_t1_pre", int'(io.time1), 1);
      @(negedge clk);
      chk("coin_t1", int'(io.time1), 0);
      chk("coin_z1", int'(io.zero1), 1);
      chk("coin_ply", int'(io.player), 0);
      chk("coin_run", int'(io.running), 0);
      repeat (8) @(negedge clk);
      chk("coin_frozen_t1", int'(io.time1), 0);
      chk("coin_no_tick", int'(io.tick), 0);

      // ---- asynchronous reset mid-RUN with a held button ----
      do_reset("mid");
      io.start_button = 1'b1;
      @(negedge clk);
      io.start_button = 1'b0;
      repeat (7) @(negedge clk);
      io.button1 = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_ply", int'(io.player), 1);
      chk("mid_run", int'(io.running), 1);
      #2 rst_n = 1'b0;
      #1 chk_out("mid_async", cur_out(), IDLE_O);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk_out($sformatf("mid_held%0d", c), cur_out(), IDLE_O);
      end
      io.button1 = 1'b0;

`ifdef FISCHER_INC_EN
      // ---- increment: move with tick at time1=2, then saturation ----
      do_reset("inc");
      io.start_button = 1'b1;
      @(negedge clk);
      io.start_button = 1'b0;
      repeat (7) @(negedge clk);
      io.button1 = 1'b1;
      @(negedge clk);
      io.button1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("inc_t1", int'(io.time1), 3);
      chk("inc_ply", int'(io.player), 1);
      for (int k = 0; k < 16; k++) begin
         if (k % 2 == 0) io.button2 = 1'b1;
         else            io.button1 = 1'b1;
         @(negedge clk);
         io.button1 = 1'b0;
         io.button2 = 1'b0;
         @(negedge clk);
      end
      @(negedge clk);
      chk("inc_sat_t1", int'(io.time1), 15);
      chk("inc_sat_t2", int'(io.time2), 15);
      chk("inc_sat_ply", int'(io.player), 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
